flexcounter_multi: RTL
======================

Name: flexcounter_multi

Overview:
Parametrised multi-channel successor to the single flexcounter. It provides NCHAN independent counters sharing one clock, one reset and one prescaler. Each channel has per-channel up/down direction, wrap or one-shot mode, and optional cascading from the previous channel. It serves as the general timing/event-count source for controllers that need several concurrent rate or timeout counters.

Parameters:
NCHAN, 4, number of counter channels (>=1)
COUNTSIZE, 1024, count range basis
COUNTWIDTH, $clog2(COUNTSIZE), bit width of each channel count/maxCount
PRESCALE, 1, shared tick divider; channels advance once per PRESCALE cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
enableCounter  input  NCHAN  per-channel advance enable
clear  input  NCHAN  per-channel synchronous clear
countDown  input  NCHAN  1 = count down, 0 = count up
oneShot  input  NCHAN  1 = stop at terminal and set done, 0 = wrap
cascade  input  NCHAN  1 = channel i advances on channel i-1 terminal event; bit 0 ignored
maxCount  input  NCHAN*COUNTWIDTH  per-channel terminal/reload value; channel i at [i*COUNTWIDTH +: COUNTWIDTH]
count  output  NCHAN*COUNTWIDTH  per-channel current count, same packing
strobe  output  NCHAN  registered one-cycle terminal pulse
done  output  NCHAN  one-shot completion flag
tick  output  1  prescaler tick (combinational from prescaler state)

Behaviour:
- Reset (nRST low, async): all count = 0, strobe = 0, done = 0, prescaler = 0.
- Prescaler: PRESCALE==1 -> tick tied 1. Otherwise psCnt free-runs 0..PRESCALE-1 and wraps; tick = (psCnt == PRESCALE-1). It is independent of channel enables.
- Source event src[i]:
  - Channel 0, or cascade[i]==0: src[i] = tick.
  - cascade[i]==1 (i>0): src[i] = term[i-1], the same-cycle combinational terminal event of channel i-1. This lets chains ripple in one cycle.
- Advance: adv[i] = src[i] & enableCounter[i] & ~done[i] & ~clear[i].
- Terminal condition:
  - Up: count >= maxCount. Use >=, not ==, so a maxCount lowered below the current count wraps on the next advance.
  - Down: count == 0.
- term[i] = adv[i] & terminal condition.
- Next count on adv:
  - Up, not terminal: count+1. Up, terminal: wrap mode -> 0; one-shot -> hold, done <= 1.
  - Down, not terminal: count-1. Down, terminal: wrap mode -> maxCount; one-shot -> hold at 0, done <= 1.
- strobe[i] <= term[i], registered, so the pulse appears the cycle after the terminal advance. strobe is high for exactly one cycle per terminal event.
- Clear has highest priority (below reset):
  - Count <= 0 (up) or maxCount (down); done <= 0; strobe <= 0 that cycle.
  - A clear suppresses term, so a cascaded successor does not advance.
- done holds the channel frozen until clear. enableCounter low also holds count, but done is unaffected.
- maxCount==0, up wrap: every advance is terminal; count stays 0; strobe follows every advance.
- After reset, a down channel sits at 0, so its first advance is terminal. Controllers clear first to load maxCount.
- countDown, oneShot, cascade and maxCount are sampled every cycle. Changing them mid-count does not reset the count.
- Arithmetic is modulo 2^COUNTWIDTH and never exceeds the maxCount range.
- Reset asserted mid-count: immediate return to reset values. Prescaler phase restarts at 0.

Test Plan:
- PRESCALE=1, ch0 up wrap, maxCount=3, enable held -> count 0,1,2,3,0,1; strobe high the cycle after each 3->0 transition; done stays 0.
- ch1 down one-shot, maxCount=5, clear 1 cycle then enable -> count 5,4,3,2,1,0; done=1 with one strobe; count holds 0 for 10 more cycles; clear -> count=5, done=0.
- ch0 up wrap maxCount=2; ch1 cascade=1, up wrap maxCount=1 -> ch1 increments only on ch0 2->0 cycles; ch1 strobe once per 6 clocks.
- PRESCALE=4, ch0 up maxCount=7 -> tick every 4th cycle; count increments once per 4 cycles; 0->7->0 takes 32 cycles.
- clear asserted in the same cycle ch0 is at terminal with ch1 cascaded -> ch0=0, no strobe, ch1 unchanged.
- ch0 counting up at 9 with maxCount=20, then maxCount changed to 4 -> next advance wraps to 0 with strobe. Separately, nRST pulsed low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/flexcounter_multi.sv
// Multi-channel flex counter: NCHAN up/down, wrap/one-shot, cascadable counters on one shared prescaler.
// Latency: count/done update on the clock after an advance; strobe is registered one cycle after the terminal advance.
// No backpressure: channels advance only on their source event while enabled, not done and not clearing.
module flexcounter_multi #(
    parameter int NCHAN      = 4,
    parameter int COUNTSIZE  = 1024,
    parameter int COUNTWIDTH = $clog2(COUNTSIZE),
    parameter int PRESCALE   = 1
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic [NCHAN-1:0]            enableCounter,
    input  logic [NCHAN-1:0]            clear,
    input  logic [NCHAN-1:0]            countDown,
    input  logic [NCHAN-1:0]            oneShot,
    input  logic [NCHAN-1:0]            cascade,
    input  logic [NCHAN*COUNTWIDTH-1:0] maxCount,
    output logic [NCHAN*COUNTWIDTH-1:0] count,
    output logic [NCHAN-1:0]            strobe,
    output logic [NCHAN-1:0]            done,
    output logic                        tick
);

    localparam int W = COUNTWIDTH;

    // Channel 0 always runs from the prescaler, so its cascade bit has no meaning.
    logic unused_cascade0;
    assign unused_cascade0 = cascade[0];

    if (PRESCALE == 1) begin : g_no_prescale
        assign tick = 1'b1;
    end else begin : g_prescale
        localparam int PSW = $clog2(PRESCALE);
        localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
        logic [PSW-1:0] ps_cnt;

        // Free-running prescaler, independent of any channel enable.
        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                ps_cnt <= '0;
            end else if (ps_cnt == PS_LAST) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + PSW'(1);
            end
        end

        assign tick = (ps_cnt == PS_LAST);
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        logic [W-1:0] cnt_q;
        logic [W-1:0] max_c;
        logic         done_q;
        logic         strobe_q;
        logic         src;
        logic         adv;
        logic         at_end;
        logic         term;

        assign max_c = maxCount[i*W +: W];

        // Cascaded channels take the predecessor's same-cycle terminal event so chains ripple in one clock.
        if (i == 0) begin : g_src_first
            assign src = tick;
        end else begin : g_src_chain
            assign src = cascade[i] ? g_ch[i-1].term : tick;
        end

        // Up uses >= so lowering maxCount below the current count wraps on the next advance.
        assign at_end = countDown[i] ? (cnt_q == '0) : (cnt_q >= max_c);
        assign adv    = src & enableCounter[i] & ~done_q & ~clear[i];
        assign term   = adv & at_end;

        // Count/done/strobe update: clear wins, then terminal handling, then plain step.
        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                cnt_q    <= '0;
                done_q   <= 1'b0;
                strobe_q <= 1'b0;
            end else begin
                strobe_q <= term;
                if (clear[i]) begin
                    cnt_q  <= countDown[i] ? max_c : '0;
                    done_q <= 1'b0;
                end else if (adv) begin
                    if (at_end) begin
                        if (oneShot[i]) begin
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= countDown[i] ? max_c : '0;
                        end
                    end else begin
                        cnt_q <= countDown[i] ? (cnt_q - W'(1)) : (cnt_q + W'(1));
                    end
                end
            end
        end

        assign count[i*W +: W] = cnt_q;
        assign strobe[i]       = strobe_q;
        assign done[i]         = done_q;
    end

endmodule
